logic_result_tx: RTL and testbench
==================================

Name: logic_result_tx

Overview:
- Transmit side for the 4-bit logical unit's results.
- On a `start` strobe it snapshots the unit's AND, OR, XOR and NOT results and sends them as a framed serial bit stream with a valid/ready handshake.
- It sits downstream of the logical unit and feeds a serial link or a display shifter.
- A matching receiver can check the frame's sync pattern and parity.

Parameters:
- W, 4, operand width; AND/OR/XOR results are W bits, the NOT result is 2W bits.
- SYNC_W, 8, sync header width in bits.
- SYNC, 8'hA5, sync header value, sent MSB-first.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to capture the inputs and send a frame
- a_in  in  W  AND result
- o_in  in  W  OR result
- ex_in  in  W  XOR result
- n_in  in  2W  NOT result
- ser_ready  in  1  sink accepts the current bit
- ser_valid  out  1  ser_data holds a valid bit
- ser_data  out  1  current frame bit
- ser_last  out  1  high with the final (parity) bit
- busy  out  1  frame in progress (not IDLE)
- done  out  1  one-cycle pulse after the parity bit is accepted

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, all outputs 0, shift register and counters cleared.
  - Reset asserted mid-frame aborts the frame immediately; no done pulse is produced.
- Frame layout, MSB-first:
  - SYNC (SYNC_W bits).
  - Payload {a_in, o_in, ex_in, n_in} (5W bits; 20 at default).
  - One even-parity bit: XOR of all payload bits.
  - Frame length is SYNC_W+5W+1 beats (29 at default).
- Capture:
  - In IDLE with start=1, the payload is registered on that edge; the next cycle state=SYNC.
  - Payload inputs are don't-care after capture.
  - Parity is computed from the captured payload.
- Handshake:
  - A beat transfers on any edge where ser_valid && ser_ready.
  - While ser_valid=1 and ser_ready=0, ser_data and ser_last hold stable.
  - ser_valid never drops before its beat transfers.
- States:
  - IDLE: ser_valid=0, busy=0. start -> SYNC.
  - SYNC: ser_valid=1, bit counter counts SYNC_W-1 down to 0. The transfer of bit 0 -> PAYLOAD.
  - PAYLOAD: ser_valid=1, captured payload is shifted out. The transfer of the 5W-th bit -> PARITY.
  - PARITY: ser_valid=1, ser_last=1. On transfer -> DONE.
  - DONE: ser_valid=0, done=1 for exactly one cycle -> IDLE.
- Latency:
  - First bit is valid the cycle after start.
  - With ser_ready held at 1, done is asserted SYNC_W+5W+2 cycles after the start edge (31 at default).
- start while busy (SYNC, PAYLOAD, PARITY or DONE) is ignored; no queuing.
- start on the same cycle as the DONE->IDLE transition is ignored. start is sampled only in IDLE.
- Counter width is clog2(max(SYNC_W, 5W)). It never wraps, because every transition is decided by a terminal count.

Decomposition:
- Shared package `logic_pkg` holds:
  - The state enum (IDLE, SYNC, PAYLOAD, PARITY, DONE).
  - Default constants W, SYNC_W and SYNC.
  - A localparam-style function for frame length (SYNC_W+5W+1).
- One natural sub-module: `piso_shift`, a parallel-load, shift-on-enable register with width parameter.
  - Instantiated once for the payload.
  - SYNC is sent from a constant indexed by the counter.

Test Plan:
- Basic frame, ser_ready=1: a=4'h8, o=4'hE, ex=4'h6, n=8'h35 (from X=C, Y=A), start pulse.
  - Required stream: 10100101, 1000, 1110, 0110, 00110101, parity 0.
  - ser_last on beat 29; done at cycle 31.
- Odd parity: a=0, o=1, ex=1, n=8'hEF (X=1, Y=0).
  - Payload has 9 ones, so the parity bit is 1 and ser_last=1 on that beat.
- Backpressure: same frame as the basic case, ser_ready toggled 0/1 every cycle.
  - The bit stream is identical to the basic case, and ser_data is stable during every stall.
  - done is asserted about 29 cycles later than in the basic case.
- Start while busy: second start pulse at beat 5 with different inputs.
  - Ignored; the frame still carries the first capture.
  - Exactly one done pulse.
- Input change after capture: change a_in..n_in every cycle after the start edge.
  - The transmitted payload equals the values present at the start edge.
- Reset mid-frame: assert rst asynchronously during PAYLOAD beat 10.
  - ser_valid, busy and done go to 0 immediately, without waiting for a clock edge.
  - No done pulse follows.
  - After release, a fresh start sends a complete correct frame.

Source files
------------

// File: rtl/logic_pkg.sv
// logic_pkg: shared states, default constants and frame sizing for the logic-result transmitter
package logic_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_PAYLOAD, ST_PARITY, ST_DONE} state_t;
  localparam int LOGIC_W = 4;
  localparam int LOGIC_SYNC_W = 8;
  localparam logic [7:0] LOGIC_SYNC = 8'hA5;
  function automatic int frame_len(input int w, input int sync_w);
    return sync_w + 5 * w + 1;
  endfunction
endpackage

// File: rtl/piso_shift.sv
// piso_shift: parallel-load register that shifts out MSB-first on enable
module piso_shift #(
  parameter int N = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [N-1:0] d,
  output logic         q
);
  logic [N-1:0] r;
  always_ff @(posedge clk or posedge rst)
    if (rst) r <= '0;
    else if (load) r <= d;
    else if (shift) r <= {r[N-2:0], 1'b0};
  assign q = r[N-1];
endmodule

// File: rtl/logic_result_tx.sv
// logic_result_tx: frames captured AND/OR/XOR/NOT results as SYNC + payload + even parity on a valid/ready bit stream
module logic_result_tx
  import logic_pkg::*;
#(
  parameter int W = LOGIC_W,
  parameter int SYNC_W = LOGIC_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC = SYNC_W'(LOGIC_SYNC)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] o_in,
  input  logic [W-1:0] ex_in,
  input  logic [2*W-1:0] n_in,
  input  logic         ser_ready,
  output logic         ser_valid,
  output logic         ser_data,
  output logic         ser_last,
  output logic         busy,
  output logic         done
);
  localparam int PW = 5 * W;
  localparam int CW = $clog2(SYNC_W > PW ? SYNC_W : PW);
  localparam int SI = SYNC_W > 1 ? $clog2(SYNC_W) : 1;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic par, pay_bit, fire, cap;
  assign cap  = state == ST_IDLE && start;
  assign fire = ser_valid && ser_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      par   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (cap) par <= ^{a_in, o_in, ex_in, n_in};
    end
  piso_shift #(.N(PW)) u_piso (
    .clk  (clk),
    .rst  (rst),
    .load (cap),
    .shift(state == ST_PAYLOAD && fire),
    .d    ({a_in, o_in, ex_in, n_in}),
    .q    (pay_bit)
  );
  // every move out of SYNC/PAYLOAD is gated by a terminal count, so cnt never wraps
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      ST_IDLE: if (start) begin
        state_n = ST_SYNC;
        cnt_n   = CW'(SYNC_W - 1);
      end
      ST_SYNC: if (fire) begin
        state_n = cnt == '0 ? ST_PAYLOAD : ST_SYNC;
        cnt_n   = cnt == '0 ? CW'(PW - 1) : cnt - CW'(1);
      end
      ST_PAYLOAD: if (fire) begin
        state_n = cnt == '0 ? ST_PARITY : ST_PAYLOAD;
        cnt_n   = cnt == '0 ? '0 : cnt - CW'(1);
      end
      ST_PARITY: if (fire) state_n = ST_DONE;
      default: state_n = ST_IDLE;
    endcase
  end
  assign ser_valid = state == ST_SYNC || state == ST_PAYLOAD || state == ST_PARITY;
  assign ser_last  = state == ST_PARITY;
  assign busy      = state != ST_IDLE;
  assign done      = state == ST_DONE;
  assign ser_data  = state == ST_SYNC    ? SYNC[cnt[SI-1:0]] :
                     state == ST_PAYLOAD ? pay_bit :
                     state == ST_PARITY  && par;
endmodule

// File: tb/tb_logic_result_tx.sv
// tb_logic_result_tx: scoreboard bench, driver queues expected frame bits and a negedge monitor checks each transferred beat
module tb_logic_result_tx;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, ser_ready = 1'b0;
  logic [3:0] a_in = '0, o_in = '0, ex_in = '0;
  logic [7:0] n_in = '0;
  logic ser_valid, ser_data, ser_last, busy, done;

  logic_result_tx dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .o_in(o_in), .ex_in(ex_in),
    .n_in(n_in), .ser_ready(ser_ready), .ser_valid(ser_valid), .ser_data(ser_data),
    .ser_last(ser_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0, beats = 0, dones = 0, done_cyc = 0;
  bit exp_q[$];
  logic pv = 1'b0, pr = 1'b0, pd = 1'b0, pl = 1'b0;

  localparam logic [28:0] F1 = 29'b10100101_1000_1110_0110_00110101_0;
  localparam logic [28:0] F2 = 29'b10100101_0000_0001_0001_11101111_1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst) pv = 1'b0;
    else begin
      if (pv && !pr) begin
        chk("stall_valid", ser_valid, 1);
        chk("stall_data", ser_data, pd);
        chk("stall_last", ser_last, pl);
      end
      if (ser_valid && ser_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %0d with no frame bit expected", ser_data);
        end else begin
          chk("beat_data", ser_data, exp_q.pop_front());
          chk("beat_last", ser_last, exp_q.size() == 0);
        end
        beats++;
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
      end
      pv = ser_valid; pr = ser_ready; pd = ser_data; pl = ser_last;
    end
  end

  // mode 0: ready=1, 1: ready toggling, 2: start while busy, 3: inputs churn, 4: reset at beat 10
  task automatic send(input logic [28:0] f, input logic [3:0] a, input logic [3:0] o,
                      input logic [3:0] x, input logic [7:0] n, input int mode, input int exp_done);
    int c0, d0;
    bit sent2;
    sent2 = 1'b0;
    for (int i = 28; i >= 0; i--) exp_q.push_back(f[i]);
    d0 = dones;
    beats = 0;
    @(posedge clk); #1;
    a_in = a; o_in = o; ex_in = x; n_in = n;
    start = 1'b1;
    ser_ready = mode != 1;
    c0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    chk("first_valid", ser_valid, 1);
    chk("first_busy", busy, 1);
    for (int k = 0; k < 200 && dones == d0; k++) begin
      if (mode == 1) ser_ready = ~ser_ready;
      if (mode == 2) begin
        start = beats == 5 && !sent2;
        if (start) begin
          sent2 = 1'b1;
          a_in = 4'hF; o_in = 4'hF; ex_in = 4'h0; n_in = 8'h00;
        end
      end
      if (mode == 3) begin
        a_in = 4'($urandom); o_in = 4'($urandom); ex_in = 4'($urandom); n_in = 8'($urandom);
      end
      if (mode == 4 && beats == 10) begin
        rst = 1'b1;
        #1;
        chk("rst_valid", ser_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (40) @(posedge clk);
        #1 chk("rst_no_done", dones - d0, 0);
        return;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    ser_ready = 1'b1;
    chk("done_seen", dones - d0, 1);
    chk("done_cycle", done_cyc - c0 + 1, exp_done);
    repeat (40) @(posedge clk);
    #1;
    chk("single_done", dones - d0, 1);
    chk("queue_empty", exp_q.size(), 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", ser_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_last", ser_last, 0);
    chk("reset_data", ser_data, 0);
    rst = 1'b0;
    send(F1, 4'h8, 4'hE, 4'h6, 8'h35, 0, 31);
    send(F2, 4'h0, 4'h1, 4'h1, 8'hEF, 0, 31);
    send(F1, 4'h8, 4'hE, 4'h6, 8'h35, 1, 59);
    send(F1, 4'h8, 4'hE, 4'h6, 8'h35, 2, 31);
    send(F2, 4'h0, 4'h1, 4'h1, 8'hEF, 3, 31);
    send(F2, 4'h0, 4'h1, 4'h1, 8'hEF, 4, 0);
    send(F1, 4'h8, 4'hE, 4'h6, 8'h35, 0, 31);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
